// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared lane/block types and the round-robin pick helper for lane_dispatch_scheduler
package crypto_pkg;

  localparam int CRYPTO_LANES     = 4;
  localparam int CRYPTO_BLOCK_W   = 32;
  localparam int CRYPTO_LANE_ID_W = $clog2(CRYPTO_LANES);
  localparam int RR_MAX_LANES     = 64;
  localparam int RR_IDX_W         = $clog2(RR_MAX_LANES);

  typedef logic [CRYPTO_LANE_ID_W-1:0] lane_id_t;
  typedef logic [CRYPTO_BLOCK_W-1:0]   block_t;

  // First set bit of mask at or above ptr, wrapping at n; mask is zero-extended to RR_MAX_LANES.
  function automatic int unsigned rr_pick(input logic [RR_MAX_LANES-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_LANES; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k < n) && mask[idx[RR_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lane_order_fifo.sv
// rtl/lane_order_fifo.sv - circular FIFO of lane ids recording block acceptance order
module lane_order_fifo
  import crypto_pkg::*;
#(
  parameter int DEPTH = CRYPTO_LANES,
  parameter int W     = CRYPTO_LANE_ID_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_id_i,
  input  logic         pop_i,
  output logic         empty_o,
  output logic         full_o,
  output logic [W-1:0] front_o
);

  localparam int CNT_W = W + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign front_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_id_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lane_dispatch_scheduler.sv
// rtl/lane_dispatch_scheduler.sv - round-robin dispatch to encrypt lanes with in-order result release
// Optional perf counters under PERF_COUNTERS_EN; without it both counters are tied to 0.
module lane_dispatch_scheduler
  import crypto_pkg::*;
#(
  parameter int BLOCK_WIDTH   = CRYPTO_BLOCK_W,
  parameter int NUM_LANES     = CRYPTO_LANES,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BLOCK_WIDTH-1:0]           data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [BLOCK_WIDTH-1:0]           data_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  input  logic [NUM_LANES-1:0]             lane_enable,
  output logic [NUM_LANES-1:0]             lane_start,
  output logic [NUM_LANES*BLOCK_WIDTH-1:0] lane_din,
  input  logic [NUM_LANES-1:0]             lane_idle,
  input  logic [NUM_LANES-1:0]             lane_done,
  input  logic [NUM_LANES*BLOCK_WIDTH-1:0] lane_dout,
  output logic                             err_spurious,
  output logic [COUNTER_WIDTH-1:0]         blocks_processed,
  output logic [COUNTER_WIDTH-1:0]         cycles_elapsed
);

  localparam int LANE_ID_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]                   issued_q, issued_d;
  logic [NUM_LANES-1:0]                   res_valid_q, res_valid_d;
  logic [NUM_LANES-1:0][BLOCK_WIDTH-1:0]  res_q;
  logic [NUM_LANES-1:0]                   lane_start_q, lane_start_d;
  logic [NUM_LANES*BLOCK_WIDTH-1:0]       lane_din_q;
  logic [LANE_ID_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                                   err_q, err_d;
  logic                                   running_q;

  logic [NUM_LANES-1:0] free;
  logic [LANE_ID_W-1:0] grant;
  logic [LANE_ID_W-1:0] head;
  logic                 fifo_empty, fifo_full;
  logic                 accept, pop;

  assign free  = lane_enable & lane_idle & ~issued_q & ~res_valid_q;
  assign grant = LANE_ID_W'(rr_pick(RR_MAX_LANES'(free), 32'(rr_ptr_q), NUM_LANES));

  // running_q keeps ready low while reset is held and for the first cycle after release.
  assign data_in_ready  = running_q & (|free) & ~fifo_full;
  assign accept         = data_in_valid & data_in_ready;
  assign data_out_valid = ~fifo_empty & res_valid_q[head];
  assign data_out       = res_q[head];
  assign pop            = data_out_valid & data_out_ready;

  assign lane_start   = lane_start_q;
  assign lane_din     = lane_din_q;
  assign err_spurious = err_q;

  lane_order_fifo #(
    .DEPTH (NUM_LANES),
    .W     (LANE_ID_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (accept),
    .push_id_i (grant),
    .pop_i     (pop),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .front_o   (head)
  );

  always_comb begin
    issued_d     = issued_q;
    res_valid_d  = res_valid_q;
    lane_start_d = '0;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q | (|(lane_done & ~issued_q));
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_done[i] && issued_q[i]) begin
        issued_d[i]    = 1'b0;
        res_valid_d[i] = 1'b1;
      end
    end
    if (pop) res_valid_d[head] = 1'b0;
    if (accept) begin
      issued_d[grant]     = 1'b1;
      lane_start_d[grant] = 1'b1;
      rr_ptr_d            = grant + LANE_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q     <= '0;
      res_valid_q  <= '0;
      res_q        <= '0;
      lane_start_q <= '0;
      lane_din_q   <= '0;
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      issued_q     <= issued_d;
      res_valid_q  <= res_valid_d;
      lane_start_q <= lane_start_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
      running_q    <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_done[i] && issued_q[i])
          res_q[i] <= lane_dout[i*BLOCK_WIDTH +: BLOCK_WIDTH];
        if (accept && (grant == LANE_ID_W'(i)))
          lane_din_q[i*BLOCK_WIDTH +: BLOCK_WIDTH] <= data_in;
      end
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] blocks_q;
  logic [COUNTER_WIDTH-1:0] cycles_q;
  logic                     started_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_q  <= '0;
      cycles_q  <= '0;
      started_q <= 1'b0;
    end else begin
      if (pop)       blocks_q  <= blocks_q + COUNTER_WIDTH'(1);
      if (started_q) cycles_q  <= cycles_q + COUNTER_WIDTH'(1);
      if (accept)    started_q <= 1'b1;
    end
  end

  assign blocks_processed = blocks_q;
  assign cycles_elapsed   = cycles_q;
`else
  assign blocks_processed = '0;
  assign cycles_elapsed   = '0;
`endif

endmodule

// File: tb/tb_lane_dispatch_scheduler.sv
// tb/tb_lane_dispatch_scheduler.sv - scoreboard bench for lane_dispatch_scheduler with latency-model engines
module tb_lane_dispatch_scheduler;
  import crypto_pkg::*;

  localparam int BW = 32;
  localparam int NL = 4;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BW-1:0]     data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_ready;
  logic [BW-1:0]     data_out;
  logic              data_out_valid;
  logic              data_out_ready = 1'b1;
  logic [NL-1:0]     lane_enable = '0;
  logic [NL-1:0]     lane_start;
  logic [NL*BW-1:0]  lane_din;
  logic [NL-1:0]     lane_idle = '1;
  logic [NL-1:0]     lane_done;
  logic [NL*BW-1:0]  lane_dout = '0;
  logic              err_spurious;
  logic [CW-1:0]     blocks_processed;
  logic [CW-1:0]     cycles_elapsed;

  logic [NL-1:0]     eng_done = '0;
  logic [NL-1:0]     spur = '0;
  int                lat [NL];
  int                cnt [NL];
  block_t            held [NL];

  int                compared = 0;
  int                mismatched = 0;
  block_t            exp_q [$];
  int                grants [$];
  logic              hold_prev = 1'b0;
  block_t            prev_data = '0;

  always #5 clk = ~clk;

  assign lane_done = eng_done | spur;

  lane_dispatch_scheduler #(
    .BLOCK_WIDTH   (BW),
    .NUM_LANES     (NL),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_ready    (data_in_ready),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .data_out_ready   (data_out_ready),
    .lane_enable      (lane_enable),
    .lane_start       (lane_start),
    .lane_din         (lane_din),
    .lane_idle        (lane_idle),
    .lane_done        (lane_done),
    .lane_dout        (lane_dout),
    .err_spurious     (err_spurious),
    .blocks_processed (blocks_processed),
    .cycles_elapsed   (cycles_elapsed)
  );

  function automatic block_t f(input block_t x);
    return {x[15:0], x[31:16]} ^ 32'hDEADBEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine model: lane_done is sampled exactly lat[i] cycles after lane_start is sampled.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done  <= '0;
      lane_idle <= '1;
      for (int i = 0; i < NL; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        eng_done[i] <= 1'b0;
        if (lane_start[i]) begin
          lane_idle[i] <= 1'b0;
          cnt[i]       <= lat[i] - 1;
          held[i]      <= lane_din[i*BW +: BW];
        end else if (!lane_idle[i]) begin
          if (cnt[i] == 0) begin
            eng_done[i]          <= 1'b1;
            lane_dout[i*BW +: BW] <= f(held[i]);
            lane_idle[i]         <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n)
      for (int i = 0; i < NL; i++)
        if (lane_start[i]) grants.push_back(i);
  end

  // Output monitor: stability while stalled, scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (rst_n && data_out_valid) begin
      if (hold_prev) chk("out_stable", data_out, prev_data);
      if (data_out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out_unexpected: got %0h expected no output", data_out);
        end else begin
          chk("out_data", data_out, exp_q.pop_front());
        end
        hold_prev = 1'b0;
      end else begin
        hold_prev = 1'b1;
        prev_data = data_out;
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    grants.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input block_t x);
    int t;
    data_in       = x;
    data_in_valid = 1'b1;
    t = 0;
    while (!data_in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!data_in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end else begin
      exp_q.push_back(f(x));
    end
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || lane_idle != '1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NL; i++) lat[i] = 8;
    repeat (3) @(negedge clk);
    chk("rst_ready", data_in_ready, 0);
    chk("rst_out_valid", data_out_valid, 0);
    chk("rst_lane_start", lane_start, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_counters", {blocks_processed, cycles_elapsed}, 0);

    // 1: single block, latency 8
    lane_enable = 4'hF;
    do_reset();
    data_in = 32'h12345678;
    data_in_valid = 1'b1;
    k = 0;
    while (!data_in_ready && k < 20) begin @(negedge clk); k++; end
    exp_q.push_back(32'h88D5ACDB);
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("t1_start", lane_start, 4'b0001);
    k = 1;
    while (!data_out_valid && k < 50) begin @(negedge clk); k++; end
    chk("t1_latency", k, 10);
    chk("t1_data", data_out, 32'h88D5ACDB);
    drain("t1_drain");

    // 2: eight back-to-back blocks
    do_reset();
    for (int b = 0; b < 8; b++) begin
      send(32'h1000_0000 + b * 32'h0101_0101);
      if (b == 3) chk("t2_ready_full", data_in_ready, 0);
    end
    drain("t2_drain");
    chk("t2_grant_count", grants.size(), 8);
    for (int b = 0; b < 8 && b < grants.size(); b++)
      chk("t2_grant", grants[b], b % 4);

    // 3: uneven latencies, results must stay in order
    do_reset();
    lat[0] = 11; lat[1] = 5; lat[2] = 8; lat[3] = 3;
    send(32'hAAAA0001);
    send(32'hBBBB0002);
    send(32'hCCCC0003);
    send(32'hDDDD0004);
    k = 0;
    while (!data_out_valid && k < 50) begin @(negedge clk); k++; end
    chk("t3_res_held", dut.res_valid_q, 4'hF);
    chk("t3_head_data", data_out, f(32'hAAAA0001));
    drain("t3_drain");
    for (int i = 0; i < NL; i++) lat[i] = 3;

    // 4: lane mask 0101
    do_reset();
    lane_enable = 4'b0101;
    for (int b = 0; b < 6; b++) send(32'h4400_0000 + b);
    drain("t4_drain");
    chk("t4_grant_count", grants.size(), 6);
    for (int b = 0; b < 6 && b < grants.size(); b++)
      chk("t4_grant", grants[b], (b % 2) * 2);
    lane_enable = 4'b0000;
    @(negedge clk);
    chk("t4_all_disabled_ready", data_in_ready, 0);
    lane_enable = 4'hF;

    // 5: output stall for 20 cycles with 4 results pending
    do_reset();
    @(posedge clk); #1 data_out_ready = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) send(32'h5500_0000 + b);
    repeat (20) @(negedge clk);
    chk("t5_valid_held", data_out_valid, 1);
    chk("t5_head_data", data_out, f(32'h5500_0000));
    @(posedge clk); #1 data_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("t5_burst", data_out_valid & data_out_ready, 1);
    end
    @(negedge clk);
    chk("t5_after_burst", data_out_valid, 0);
`ifdef PERF_COUNTERS_EN
    chk("t5_blocks", blocks_processed, 4);
    chk("t5_cycles_run", cycles_elapsed != 0, 1);
`else
    chk("t5_blocks", blocks_processed, 0);
    chk("t5_cycles_run", cycles_elapsed, 0);
`endif
    drain("t5_drain");

    // 6: spurious done, then reset mid-run
    do_reset();
    spur = 4'b0100;
    @(negedge clk);
    spur = 4'b0000;
    @(negedge clk);
    chk("t6_err", err_spurious, 1);
    chk("t6_no_output", data_out_valid, 0);
    lat[0] = 8;
    send(32'h6600_0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_outputs", {data_out_valid, lane_start, err_spurious, data_in_ready}, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_counters", {blocks_processed, cycles_elapsed}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_fifo_empty", dut.u_fifo.empty_o, 1);
    chk("t6_ready_back", data_in_ready, 1);
    repeat (15) @(negedge clk);
    chk("t6_no_stale_output", data_out_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
